// File: rtl/emc_slave.sv
// emc_slave: asynchronous EMC (external memory controller) slave bridged to a single-strobe internal bus.
// Optional byte-lane selects from BLSN are enabled with the EMC_SLAVE_BLSN_EN macro.
`default_nettype none

module emc_slave #(
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int RD_TMO = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   A,
  input  logic [DW-1:0]   D_i,
  output logic [DW-1:0]   D_o,
  output logic            D_oe,
  input  logic [3:0]      BLSN,
  input  logic            WEN,
  input  logic            OEN,
  input  logic            CSN,
  output logic [AW-1:0]   adr_o,
  output logic [DW-1:0]   dat_o,
  output logic [DW/8-1:0] sel_o,
  output logic            we_o,
  output logic            stb_o,
  input  logic [DW-1:0]   dat_i,
  input  logic            ack_i,
  output logic            tmo_o
);

  localparam int SW = DW / 8;
  localparam int CW = (RD_TMO > 1) ? $clog2(RD_TMO + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(RD_TMO - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_CAP   = 3'd1,
    RD_REQ   = 3'd2,
    RD_DRV   = 3'd3,
    WAIT_END = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      csn_sync_q, wen_sync_q, oen_sync_q;
  logic [1:0]      warm_q;
  logic            armed_q;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            we_q, we_d;
  logic            stb_q, stb_d;
  logic            doe_q, doe_d;
  logic [DW-1:0]   do_q, do_d;
  logic            tmo_q, tmo_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            csn_s, wen_s, oen_s;
  logic            drive_ok;
  logic [SW-1:0]   sel_wr;
  logic            blsn_unused;

  assign csn_s    = csn_sync_q[1];
  assign wen_s    = wen_sync_q[1];
  assign oen_s    = oen_sync_q[1];
  assign drive_ok = !oen_s && !csn_s && wen_s;

`ifdef EMC_SLAVE_BLSN_EN
  assign sel_wr = ~BLSN[SW-1:0];
`else
  assign sel_wr = '1;
`endif
  assign blsn_unused = ^BLSN;

  // warm_q marks when the synchronisers hold real pad samples, so a CSN held
  // low across reset is never mistaken for a fresh chip-select cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      csn_sync_q <= 2'b11;
      wen_sync_q <= 2'b11;
      oen_sync_q <= 2'b11;
      warm_q     <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      csn_sync_q <= {csn_sync_q[0], CSN};
      wen_sync_q <= {wen_sync_q[0], WEN};
      oen_sync_q <= {oen_sync_q[0], OEN};
      warm_q     <= {warm_q[0], 1'b1};
      armed_q    <= armed_q | (warm_q[1] & csn_s);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '1;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
      doe_q   <= 1'b0;
      do_q    <= '0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
      doe_q   <= doe_d;
      do_q    <= do_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    stb_d   = 1'b0;
    doe_d   = 1'b0;
    do_d    = do_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (armed_q && !csn_s) begin
          if (!wen_s) begin
            // Capture on entry too, so a one-cycle WEN pulse still carries A/D.
            state_d = WR_CAP;
            adr_d   = A;
            dat_d   = D_i;
            sel_d   = sel_wr;
          end else if (!oen_s) begin
            state_d = RD_REQ;
            adr_d   = A;
            sel_d   = '1;
            we_d    = 1'b0;
            stb_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      WR_CAP: begin
        if (wen_s || csn_s) begin
          stb_d   = 1'b1;
          we_d    = 1'b1;
          state_d = WAIT_END;
        end else begin
          adr_d = A;
          dat_d = D_i;
          sel_d = sel_wr;
        end
      end
      RD_REQ: begin
        if (csn_s) begin
          state_d = IDLE;
        end else if (ack_i) begin
          do_d    = dat_i;
          doe_d   = drive_ok;
          state_d = RD_DRV;
        end else if (cnt_q == TMO_LAST) begin
          do_d    = '0;
          tmo_d   = 1'b1;
          doe_d   = drive_ok;
          state_d = RD_DRV;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_DRV: begin
        if (oen_s || csn_s) begin
          state_d = WAIT_END;
        end else begin
          doe_d = drive_ok;
        end
      end
      WAIT_END: begin
        if (csn_s || (wen_s && oen_s)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign adr_o = adr_q;
  assign dat_o = dat_q;
  assign sel_o = sel_q;
  assign we_o  = we_q;
  assign stb_o = stb_q;
  assign D_oe  = doe_q;
  assign D_o   = do_q;
  assign tmo_o = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_emc_slave.sv
// tb_emc_slave: randomized EMC bus transactions checked against a transaction-level expectation model.
`default_nettype none

module tb_emc_slave;

  localparam int AW     = 8;
  localparam int DW     = 16;
  localparam int RD_TMO = 15;
  localparam int SW     = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [AW-1:0] A     = '0;
  logic [DW-1:0] D_i   = '0;
  logic [DW-1:0] D_o;
  logic          D_oe;
  logic [3:0]    BLSN  = 4'hF;
  logic          WEN   = 1'b1;
  logic          OEN   = 1'b1;
  logic          CSN   = 1'b1;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [SW-1:0] sel_o;
  logic          we_o;
  logic          stb_o;
  logic [DW-1:0] dat_i = '0;
  logic          ack_i = 1'b0;
  logic          tmo_o;

  emc_slave #(.AW(AW), .DW(DW), .RD_TMO(RD_TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .A(A), .D_i(D_i), .D_o(D_o), .D_oe(D_oe),
    .BLSN(BLSN), .WEN(WEN), .OEN(OEN), .CSN(CSN), .adr_o(adr_o), .dat_o(dat_o),
    .sel_o(sel_o), .we_o(we_o), .stb_o(stb_o), .dat_i(dat_i), .ack_i(ack_i),
    .tmo_o(tmo_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int            pass_cnt = 0;
  int            chk_cnt  = 0;
  int            stb_cnt  = 0;
  int            dbl_stb  = 0;
  int            mon_cyc  = 0;
  logic          prev_stb = 1'b0;
  logic [AW-1:0] mon_adr;
  logic [DW-1:0] mon_dat;
  logic [SW-1:0] mon_sel;
  logic          mon_we;

  always @(negedge clk_i) begin
    if (stb_o === 1'b1) begin
      stb_cnt++;
      if (prev_stb) dbl_stb++;
      mon_adr = adr_o;
      mon_dat = dat_o;
      mon_sel = sel_o;
      mon_we  = we_o;
      mon_cyc = cyc;
    end
    prev_stb = (stb_o === 1'b1);
  end

  function automatic logic [SW-1:0] exp_sel(input logic [3:0] bl);
`ifdef EMC_SLAVE_BLSN_EN
    logic [3:0] inv;
    inv = ~bl;
    return inv[SW-1:0];
`else
    return {SW{1'b1}};
`endif
  endfunction

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic emc_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] bl);
    int s0, t_rise, k;
    s0 = stb_cnt;
    @(posedge clk_i); #1;
    A = a; D_i = d; BLSN = bl; CSN = 1'b0; WEN = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge clk_i);
    #1;
    WEN = 1'b1;
    t_rise = cyc;
    k = 0;
    while (stb_cnt == s0 && k < 8) begin tick(); k++; end
    repeat (3) tick();
    CSN = 1'b1;
    repeat (4) tick();
    chk_cnt++;
    if (stb_cnt - s0 !== 1) $display("FAIL wr_stb_count: got %0d required 1", stb_cnt - s0);
    else pass_cnt++;
    chk_cnt++;
    if (!(mon_cyc - t_rise <= 4 && mon_cyc > t_rise))
      $display("FAIL wr_latency: got %0d cycles required <=4", mon_cyc - t_rise);
    else pass_cnt++;
    chk_cnt++;
    if (mon_we !== 1'b1) $display("FAIL wr_we: got %b required 1", mon_we);
    else pass_cnt++;
    chk_cnt++;
    if (mon_adr !== a) $display("FAIL wr_adr: got %h required %h", mon_adr, a);
    else pass_cnt++;
    chk_cnt++;
    if (mon_dat !== d) $display("FAIL wr_dat: got %h required %h", mon_dat, d);
    else pass_cnt++;
    chk_cnt++;
    if (mon_sel !== exp_sel(bl)) $display("FAIL wr_sel: got %b required %b", mon_sel, exp_sel(bl));
    else pass_cnt++;
  endtask

  task automatic emc_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int dly);
    int s0, t_fall, k;
    s0 = stb_cnt;
    @(posedge clk_i); #1;
    A = a; CSN = 1'b0; OEN = 1'b0;
    t_fall = cyc;
    k = 0;
    while (stb_cnt == s0 && k < 8) begin tick(); k++; end
    chk_cnt++;
    if (!(stb_cnt == s0 + 1 && mon_cyc - t_fall <= 4))
      $display("FAIL rd_stb: got count %0d latency %0d required 1 and <=4", stb_cnt - s0, mon_cyc - t_fall);
    else pass_cnt++;
    chk_cnt++;
    if (mon_we !== 1'b0 || mon_adr !== a)
      $display("FAIL rd_req: got we %b adr %h required we 0 adr %h", mon_we, mon_adr, a);
    else pass_cnt++;
    repeat (dly) tick();
    ack_i = 1'b1; dat_i = d;
    tick();
    ack_i = 1'b0; dat_i = DW'($urandom);
    k = 0;
    while (D_oe !== 1'b1 && k < 3) begin tick(); k++; end
    chk_cnt++;
    if (D_oe !== 1'b1 || k > 1) $display("FAIL rd_doe_on: got D_oe %b after %0d extra cycles required 1 within 2", D_oe, k);
    else pass_cnt++;
    repeat (3) tick();
    chk_cnt++;
    if (D_oe !== 1'b1 || D_o !== d) $display("FAIL rd_data: got D_oe %b D %h required 1 %h", D_oe, D_o, d);
    else pass_cnt++;
    OEN = 1'b1;
    k = 0;
    while (D_oe !== 1'b0 && k < 6) begin tick(); k++; end
    chk_cnt++;
    if (D_oe !== 1'b0 || k > 3) $display("FAIL rd_doe_off: got %0d cycles required <=3", k);
    else pass_cnt++;
    CSN = 1'b1;
    repeat (4) tick();
    chk_cnt++;
    if (stb_cnt - s0 !== 1) $display("FAIL rd_stb_total: got %0d required 1", stb_cnt - s0);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #2 rst_i = 1'b0;
    #1;
    chk_cnt++;
    if (stb_o !== 1'b0 || we_o !== 1'b0 || D_oe !== 1'b0 || tmo_o !== 1'b0)
      $display("FAIL reset_ctrl: got stb %b we %b oe %b tmo %b required 0", stb_o, we_o, D_oe, tmo_o);
    else pass_cnt++;
    chk_cnt++;
    if (adr_o !== '0 || dat_o !== '0 || D_o !== '0 || sel_o !== {SW{1'b1}})
      $display("FAIL reset_data: got adr %h dat %h D %h sel %b required 0 0 0 all-ones", adr_o, dat_o, D_o, sel_o);
    else pass_cnt++;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #1;
    rst_i = 1'b1;
    repeat (5) tick();
    chk_cnt++;
    if (stb_cnt !== 0) $display("FAIL reset_no_stb: got %0d required 0", stb_cnt);
    else pass_cnt++;
  endtask

  task automatic test_write();
    emc_write(8'hA5, 16'hABCD, 4'b0000);
    emc_write(8'h20, 16'h1234, 4'b1110);
    for (int i = 0; i < 5; i++)
      emc_write(AW'($urandom), DW'($urandom), 4'($urandom));
  endtask

  task automatic test_read();
    emc_read(8'h07, 16'hBA98, 2);
    for (int i = 0; i < 5; i++)
      emc_read(AW'($urandom), DW'($urandom_range(1, 16'hFFFF)), $urandom_range(0, 6));
  endtask

  task automatic test_timeout();
    int s0, k;
    s0 = stb_cnt;
    @(posedge clk_i); #1;
    A = 8'h10; CSN = 1'b0; OEN = 1'b0;
    k = 0;
    while (stb_cnt == s0 && k < 8) begin tick(); k++; end
    k = 0;
    while (tmo_o !== 1'b1 && k < RD_TMO + 5) begin tick(); k++; end
    chk_cnt++;
    if (tmo_o !== 1'b1 || k < RD_TMO || k > RD_TMO + 1)
      $display("FAIL tmo_time: got tmo %b after %0d cycles required 1 after %0d", tmo_o, k, RD_TMO);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (D_oe !== 1'b1 || D_o !== '0) $display("FAIL tmo_data: got oe %b D %h required 1 0000", D_oe, D_o);
    else pass_cnt++;
    OEN = 1'b1;
    repeat (4) tick();
    CSN = 1'b1;
    repeat (4) tick();
    emc_read(AW'($urandom), 16'h5A5A, 1);
    chk_cnt++;
    if (tmo_o !== 1'b1) $display("FAIL tmo_sticky: got %b required 1", tmo_o);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int s0, k, seen;
    s0 = stb_cnt;
    @(posedge clk_i); #1;
    A = AW'($urandom); CSN = 1'b0; OEN = 1'b0;
    k = 0;
    while (stb_cnt == s0 && k < 8) begin tick(); k++; end
    CSN = 1'b1; OEN = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      ack_i = (i == 4);
      dat_i = 16'hFFFF;
      tick();
      if (D_oe !== 1'b0) seen++;
    end
    ack_i = 1'b0;
    chk_cnt++;
    if (seen != 0 || stb_cnt - s0 != 1)
      $display("FAIL abort: got oe-cycles %0d stb %0d required 0 and 1", seen, stb_cnt - s0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) emc_write(AW'($urandom), DW'($urandom), 4'($urandom));
      else emc_read(AW'($urandom), DW'($urandom), $urandom_range(0, 4));
    end
  endtask

  task automatic test_reset_mid();
    int s0, k;
    s0 = stb_cnt;
    @(posedge clk_i); #1;
    A = AW'($urandom); CSN = 1'b0; OEN = 1'b0;
    k = 0;
    while (stb_cnt == s0 && k < 8) begin tick(); k++; end
    ack_i = 1'b1; dat_i = 16'hC3C3;
    tick();
    ack_i = 1'b0;
    tick();
    chk_cnt++;
    if (D_oe !== 1'b1) $display("FAIL rstmid_pre: got oe %b required 1", D_oe);
    else pass_cnt++;
    rst_i = 1'b0;
    #1;
    chk_cnt++;
    if (D_oe !== 1'b0 || stb_o !== 1'b0 || tmo_o !== 1'b0 || D_o !== '0 || adr_o !== '0)
      $display("FAIL rstmid_async: got oe %b stb %b tmo %b D %h adr %h required all 0", D_oe, stb_o, tmo_o, D_o, adr_o);
    else pass_cnt++;
    #10 rst_i = 1'b1;
    s0 = stb_cnt;
    repeat (10) tick();
    chk_cnt++;
    if (stb_cnt != s0 || D_oe !== 1'b0) $display("FAIL rstmid_stale: got stb %0d oe %b required 0 0", stb_cnt - s0, D_oe);
    else pass_cnt++;
    CSN = 1'b1; OEN = 1'b1;
    repeat (4) tick();
    emc_read(AW'($urandom), 16'h0F0F, 0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    chk_cnt++;
    if (dbl_stb != 0) $display("FAIL stb_single: got %0d back-to-back strobes required 0", dbl_stb);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
